// File: rtl/err_ctrl_pkg.sv
// Shared types and defaults for the error-injector sweep controller.
package err_ctrl_pkg;

    localparam int DEF_CNT_W    = 12;
    localparam int DEF_LEN_W    = 16;
    localparam int DEF_STEP_W   = 4;
    localparam int CLEAR_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/err_rate_stepper.sv
// Next injector error period: saturating base+incr, clamped to a minimum of 1.
module err_rate_stepper
    import err_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic [CNT_W-1:0] base,
    input  logic [CNT_W-1:0] incr,
    output logic [CNT_W-1:0] rate_next
);

    // A period of 0 would stall the injector counter, so 1 is the floor.
    function automatic logic [CNT_W-1:0] sat_clamp(input logic [CNT_W:0] sum);
        if (sum[CNT_W]) return '1;
        if (sum[CNT_W-1:0] == '0) return CNT_W'(1);
        return sum[CNT_W-1:0];
    endfunction

    assign rate_next = sat_clamp({1'b0, base} + {1'b0, incr});

endmodule

// File: rtl/err_sweep_ctrl.sv
// Steps the bit-error injector through a sweep of error periods, one frame of
// valid words per step.
module err_sweep_ctrl
    import err_ctrl_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [LEN_W-1:0]  i_frame_len,
    input  logic [STEP_W-1:0] i_n_steps,
    input  logic [CNT_W-1:0]  i_first_err,
    input  logic [CNT_W-1:0]  i_rate_base,
    input  logic [CNT_W-1:0]  i_rate_step,
    input  logic              i_vld,
    output logic              o_gen_reset_n,
    output logic              o_err_enable,
    output logic [CNT_W-1:0]  o_first_err,
    output logic [CNT_W-1:0]  o_err_rate,
    output logic [STEP_W-1:0] o_step_idx,
    output logic [LEN_W-1:0]  o_word_cnt,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CLR_W = 2;

    state_t            state_q, state_nxt;
    logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_nxt;
    logic [LEN_W-1:0]  frame_len_q;
    logic [STEP_W-1:0] n_steps_q;
    logic [CNT_W-1:0]  rate_step_q;

    logic              latch;
    logic [CNT_W-1:0]  first_err_nxt, rate_nxt;
    logic [STEP_W-1:0] step_idx_nxt;
    logic [LEN_W-1:0]  word_cnt_nxt;
    logic [CNT_W-1:0]  step_base, step_incr, rate_stepped;

    // Shared between the initial clamp on start (incr=0) and the per-step advance.
    err_rate_stepper #(.CNT_W(CNT_W)) u_stepper (
        .base      (step_base),
        .incr      (step_incr),
        .rate_next (rate_stepped)
    );

    always_comb begin
        state_nxt     = state_q;
        clr_cnt_nxt   = clr_cnt_q;
        latch         = 1'b0;
        first_err_nxt = o_first_err;
        rate_nxt      = o_err_rate;
        step_idx_nxt  = o_step_idx;
        word_cnt_nxt  = o_word_cnt;
        step_base     = o_err_rate;
        step_incr     = rate_step_q;

        case (state_q)
            IDLE: begin
                step_base = i_rate_base;
                step_incr = '0;
                if (i_start) begin
                    latch         = 1'b1;
                    first_err_nxt = i_first_err;
                    rate_nxt      = rate_stepped;
                    step_idx_nxt  = '0;
                    clr_cnt_nxt   = '0;
                    state_nxt     = (i_n_steps == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                word_cnt_nxt = '0;
                if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_nxt = RUN;
                end else begin
                    clr_cnt_nxt = clr_cnt_q + CLR_W'(1);
                end
            end
            RUN: begin
                if (frame_len_q == '0) begin
                    state_nxt = NEXT;
                end else if (i_vld) begin
                    word_cnt_nxt = o_word_cnt + LEN_W'(1);
                    if (o_word_cnt == frame_len_q - LEN_W'(1)) state_nxt = NEXT;
                end
            end
            NEXT: begin
                rate_nxt = rate_stepped;
                // n_steps_q is non-zero here: a zero step count never leaves IDLE for CLEAR.
                if (o_step_idx == n_steps_q - STEP_W'(1)) begin
                    state_nxt = DONE;
                end else begin
                    step_idx_nxt = o_step_idx + STEP_W'(1);
                    clr_cnt_nxt  = '0;
                    state_nxt    = CLEAR;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Abort freezes the counters and drops the sweep, even on the last word.
        if (i_abort && state_q != IDLE) begin
            state_nxt    = IDLE;
            rate_nxt     = o_err_rate;
            step_idx_nxt = o_step_idx;
            word_cnt_nxt = o_word_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            clr_cnt_q     <= '0;
            o_gen_reset_n <= 1'b1;
            o_err_enable  <= 1'b0;
            o_first_err   <= '0;
            o_err_rate    <= '0;
            o_step_idx    <= '0;
            o_word_cnt    <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            clr_cnt_q     <= clr_cnt_nxt;
            o_gen_reset_n <= (state_nxt != CLEAR);
            o_err_enable  <= (state_nxt == RUN);
            o_first_err   <= first_err_nxt;
            o_err_rate    <= rate_nxt;
            o_step_idx    <= step_idx_nxt;
            o_word_cnt    <= word_cnt_nxt;
            o_busy        <= (state_nxt == CLEAR) || (state_nxt == RUN) || (state_nxt == NEXT);
            o_done        <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            frame_len_q <= i_frame_len;
            n_steps_q   <= i_n_steps;
            rate_step_q <= i_rate_step;
        end
    end

endmodule
